// File: rtl/pmux_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pmux_pipe_pkg : stage-count helper and resolution-mode codes for pmux_pipe
// rev 1.0
// ---------------------------------------------------------------------------
package pmux_pipe_pkg;

   localparam int PRIO_ONEHOT  = 0;
   localparam int PRIO_HIGHEST = 1;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   function automatic int min_int(input int x, input int y);
      return (x < y) ? x : y;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pmux_pipe_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pmux_pipe_stage : resolves NSEL select bits and registers the unconsumed rest
// rev 1.0
// ---------------------------------------------------------------------------
module pmux_pipe_stage
   import pmux_pipe_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int NSEL     = 1,
   parameter int REM      = 0,
   parameter int PRIORITY = PRIO_HIGHEST
) (
   input  logic                                   clk,
   input  logic                                   srst,
   input  logic                                   in_valid,
   input  logic                                   ready,
   output logic                                   valid,
   input  logic [WIDTH-1:0]                       acc_in,
   input  logic                                   hit_in,
   input  logic                                   multi_in,
   input  logic [WIDTH*(NSEL+REM)-1:0]            b_in,
   input  logic [NSEL+REM-1:0]                    s_in,
   output logic [WIDTH-1:0]                       acc,
   output logic                                   hit,
   output logic                                   multi,
   output logic [WIDTH*((REM > 0) ? REM : 1)-1:0] b_rem,
   output logic [((REM > 0) ? REM : 1)-1:0]       s_rem
);

   logic             load;
   logic             any_sel;
   logic             many_sel;
   logic [WIDTH-1:0] last_val;
   logic [WIDTH-1:0] or_val;
   logic [WIDTH-1:0] acc_next;

   assign load = in_valid & ready;

   always_comb begin
      any_sel  = 1'b0;
      many_sel = 1'b0;
      last_val = acc_in;
      or_val   = '0;
      for (int i = 0; i < NSEL; i++) begin
         if (s_in[i]) begin
            many_sel = many_sel | any_sel;
            any_sel  = 1'b1;
            last_val = b_in[WIDTH*i +: WIDTH];
            or_val   = or_val | b_in[WIDTH*i +: WIDTH];
         end
      end
      // With no hit so far acc_in still equals A, so passing it through covers both n = 0 cases.
      if (!any_sel)
         acc_next = acc_in;
      else if (PRIORITY == PRIO_HIGHEST)
         acc_next = last_val;
      else
         acc_next = or_val | (hit_in ? acc_in : '0);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         valid <= 1'b0;
         acc   <= '0;
         hit   <= 1'b0;
         multi <= 1'b0;
      end else begin
         if (ready)
            valid <= in_valid;
         if (load) begin
            acc   <= acc_next;
            hit   <= hit_in | any_sel;
            multi <= multi_in | many_sel | (hit_in & any_sel);
         end
      end
   end

   generate
      if (REM > 0) begin : g_carry
         always_ff @(posedge clk) begin
            if (srst) begin
               b_rem <= '0;
               s_rem <= '0;
            end else if (load) begin
               b_rem <= b_in[WIDTH*(NSEL+REM)-1:WIDTH*NSEL];
               s_rem <= s_in[NSEL+REM-1:NSEL];
            end
         end
      end else begin : g_no_carry
         assign b_rem = '0;
         assign s_rem = '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/pmux_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pmux_pipe : pipelined valid/ready parallel mux, CHUNK select bits per stage
// rev 1.0
// ---------------------------------------------------------------------------
module pmux_pipe
   import pmux_pipe_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int S_WIDTH  = 1,
   parameter int CHUNK    = 1,
   parameter int PRIORITY = PRIO_HIGHEST
) (
   input  logic                       CLK,
   input  logic                       SRST,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [WIDTH-1:0]           A,
   input  logic [WIDTH*S_WIDTH-1:0]   B,
   input  logic [S_WIDTH-1:0]         S,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [WIDTH-1:0]           Y,
   output logic                       MULTI
);

   localparam int NSTAGES = ceil_div(S_WIDTH, CHUNK);

   // Index k is the input side of stage k; index k+1 is its registered output.
   logic [NSTAGES:0]           valid_c;
   logic [NSTAGES-1:0]         ready_c;
   logic [WIDTH-1:0]           acc_c   [NSTAGES+1];
   logic                       hit_c   [NSTAGES+1];
   logic                       multi_c [NSTAGES+1];
   logic [WIDTH*S_WIDTH-1:0]   b_c     [NSTAGES+1];
   logic [S_WIDTH-1:0]         s_c     [NSTAGES+1];

   assign valid_c[0] = IN_VALID;
   assign acc_c[0]   = A;
   assign hit_c[0]   = 1'b0;
   assign multi_c[0] = 1'b0;
   assign b_c[0]     = B;
   assign s_c[0]     = S;

   generate
      for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
         localparam int BASE  = k * CHUNK;
         localparam int NSEL  = min_int(CHUNK, S_WIDTH - BASE);
         localparam int REM   = S_WIDTH - BASE - NSEL;
         localparam int REM_W = (REM > 0) ? REM : 1;

         logic [WIDTH*REM_W-1:0] b_rem;
         logic [REM_W-1:0]       s_rem;

         // Unrolled ready chain: a stage can move unless it and every stage after it is full and stalled.
         assign ready_c[k] = OUT_READY | ~(&valid_c[NSTAGES:k+1]);

         pmux_pipe_stage #(
            .WIDTH    (WIDTH),
            .NSEL     (NSEL),
            .REM      (REM),
            .PRIORITY (PRIORITY)
         ) u_stage (
            .clk      (CLK),
            .srst     (SRST),
            .in_valid (valid_c[k]),
            .ready    (ready_c[k]),
            .valid    (valid_c[k+1]),
            .acc_in   (acc_c[k]),
            .hit_in   (hit_c[k]),
            .multi_in (multi_c[k]),
            .b_in     (b_c[k][WIDTH*(NSEL+REM)-1:0]),
            .s_in     (s_c[k][NSEL+REM-1:0]),
            .acc      (acc_c[k+1]),
            .hit      (hit_c[k+1]),
            .multi    (multi_c[k+1]),
            .b_rem    (b_rem),
            .s_rem    (s_rem)
         );

         assign b_c[k+1] = (WIDTH*S_WIDTH)'(b_rem);
         assign s_c[k+1] = S_WIDTH'(s_rem);
      end
   endgenerate

   assign IN_READY  = ready_c[0] & ~SRST;
   assign OUT_VALID = valid_c[NSTAGES];
   assign Y         = acc_c[NSTAGES];
   assign MULTI     = multi_c[NSTAGES];

endmodule
`default_nettype wire

// File: tb/tb_pmux_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pmux_pipe : drives PRIORITY=1 and PRIORITY=0 instances with shared stimulus
// rev 1.0
// ---------------------------------------------------------------------------
module tb_pmux_pipe;

   localparam logic [19:0] B_FIX = {4'h6, 4'h8, 4'h4, 4'h2, 4'h1};

   logic        clk = 1'b0;
   logic        srst;
   logic        in_valid;
   logic        out_ready;
   logic [3:0]  a;
   logic [19:0] b;
   logic [4:0]  s;

   logic        in_ready_p, out_valid_p, multi_p;
   logic [3:0]  y_p;
   logic        in_ready_o, out_valid_o, multi_o;
   logic [3:0]  y_o;

   int checks = 0;
   int errors = 0;

   logic [4:0] q_p [$];
   logic [4:0] q_o [$];
   logic [4:0] exp_p, exp_o;
   bit         acc_now, ret_now, have_exp;

   always #5 clk = ~clk;

   pmux_pipe #(.WIDTH(4), .S_WIDTH(5), .CHUNK(2), .PRIORITY(1)) dut_p (
      .CLK(clk), .SRST(srst), .IN_VALID(in_valid), .IN_READY(in_ready_p),
      .A(a), .B(b), .S(s), .OUT_VALID(out_valid_p), .OUT_READY(out_ready),
      .Y(y_p), .MULTI(multi_p)
   );

   pmux_pipe #(.WIDTH(4), .S_WIDTH(5), .CHUNK(2), .PRIORITY(0)) dut_o (
      .CLK(clk), .SRST(srst), .IN_VALID(in_valid), .IN_READY(in_ready_o),
      .A(a), .B(b), .S(s), .OUT_VALID(out_valid_o), .OUT_READY(out_ready),
      .Y(y_o), .MULTI(multi_o)
   );

   // Reference: flat view of the whole select vector, no notion of stages.
   function automatic logic [3:0] ref_y(input logic [3:0] av, input logic [19:0] bv,
                                        input logic [4:0] sv, input bit prio);
      logic [3:0] r;
      if (sv == 5'b0) return av;
      r = 4'h0;
      for (int i = 0; i < 5; i++)
         if (sv[i]) r = prio ? bv[4*i +: 4] : (r | bv[4*i +: 4]);
      return r;
   endfunction

   function automatic logic ref_multi(input logic [4:0] sv);
      return $countones(sv) > 1;
   endfunction

   function automatic logic [4:0] rand_s();
      int mode;
      mode = $urandom_range(0, 3);
      if (mode == 0) return 5'b0;
      if (mode == 1) return 5'(1 << $urandom_range(0, 4));
      return 5'($urandom);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      a = 4'($urandom);
      b = 20'($urandom);
      s = rand_s();
   endtask

   // Records this cycle's handshakes: pops the expected result on retire, pushes the model result on accept.
   task automatic account();
      acc_now  = in_valid && in_ready_p;
      ret_now  = out_valid_p && out_ready;
      have_exp = 1'b0;
      if (ret_now && q_p.size() > 0) begin
         exp_p    = q_p.pop_front();
         exp_o    = q_o.pop_front();
         have_exp = 1'b1;
      end
      if (acc_now) begin
         q_p.push_back({ref_multi(s), ref_y(a, b, s, 1'b1)});
         q_o.push_back({ref_multi(s), ref_y(a, b, s, 1'b0)});
      end
   endtask

   task automatic test_reset();
      int spurious;
      srst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      rand_data();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (in_ready_p !== 1'b0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got p=%b o=%b, expected 0", in_ready_p, in_ready_o);
         end
         step();
      end
      srst = 1'b0; in_valid = 1'b0;
      q_p.delete(); q_o.delete();
      #1;
      checks++;
      if (out_valid_p !== 1'b0 || y_p !== 4'h0 || multi_p !== 1'b0 ||
          out_valid_o !== 1'b0 || y_o !== 4'h0 || multi_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got p v=%b y=%h m=%b o v=%b y=%h m=%b, expected all 0",
                  out_valid_p, y_p, multi_p, out_valid_o, y_o, multi_o);
      end
      step();
      spurious = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (out_valid_p !== 1'b0 || out_valid_o !== 1'b0) spurious++;
         step();
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL reset_no_accept: got %0d output cycles, expected 0", spurious);
      end
   endtask

   task automatic test_single(input logic [4:0] sv, input logic [3:0] ey_p, input logic [3:0] ey_o,
                              input logic em, input string name);
      bit         got, done;
      int         lat;
      logic [3:0] cyp, cyo;
      logic       cmp, cmo;
      got = 0; done = 0; lat = -1;
      cyp = 'x; cyo = 'x; cmp = 'x; cmo = 'x;
      a = 4'hA; b = B_FIX; s = sv; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         #1; account(); got = acc_now; step();
      end
      in_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_accept: beat not accepted within 10 cycles", name);
      end
      for (int i = 1; i <= 12 && !done; i++) begin
         #1; account();
         if (ret_now) begin
            done = 1; lat = i;
            cyp = y_p; cyo = y_o; cmp = multi_p; cmo = multi_o;
         end
         step();
      end
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL %s_latency: got %0d, expected 3", name, lat);
      end
      checks++;
      if (cyp !== ey_p || cmp !== em) begin
         errors++;
         $display("FAIL %s_prio: got y=%h m=%b, expected y=%h m=%b", name, cyp, cmp, ey_p, em);
      end
      checks++;
      if (cyo !== ey_o || cmo !== em) begin
         errors++;
         $display("FAIL %s_onehot: got y=%h m=%b, expected y=%h m=%b", name, cyo, cmo, ey_o, em);
      end
   endtask

   task automatic test_random(input int n);
      int sent, cyc, bad, retired;
      sent = 0; cyc = 0; bad = 0; retired = 0;
      while (sent < n && cyc < 2000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_data();
         #1; account();
         if (acc_now) sent++;
         if (ret_now) begin
            retired++;
            checks++;
            if (!have_exp || {multi_p, y_p} !== exp_p || {multi_o, y_o} !== exp_o) begin
               errors++;
               $display("FAIL rand_result: got p=%h/%b o=%h/%b, expected p=%h o=%h (queued=%0b)",
                        y_p, multi_p, y_o, multi_o, exp_p, exp_o, have_exp);
            end
         end
         step(); cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && q_p.size() > 0; i++) begin
         #1; account();
         if (ret_now) begin
            retired++;
            checks++;
            if (!have_exp || {multi_p, y_p} !== exp_p || {multi_o, y_o} !== exp_o) begin
               errors++;
               $display("FAIL rand_drain_result: got p=%h/%b o=%h/%b, expected p=%h o=%h",
                        y_p, multi_p, y_o, multi_o, exp_p, exp_o);
            end
         end
         step();
      end
      checks++;
      if (sent != n || retired != n || q_p.size() != 0) begin
         errors++;
         $display("FAIL rand_count: got sent=%0d retired=%0d left=%0d, expected %0d/%0d/0",
                  sent, retired, q_p.size(), n, n);
      end
   endtask

   task automatic test_back_to_back();
      int         n_sent, n_got, extra;
      bit         need_new, prev_stall;
      logic [3:0] prev_yp, prev_yo;
      logic       prev_mp, prev_mo;
      n_sent = 0; n_got = 0; need_new = 1; prev_stall = 0;
      prev_yp = '0; prev_yo = '0; prev_mp = 0; prev_mo = 0;
      for (int cyc = 0; cyc < 40 && n_got < 6; cyc++) begin
         out_ready = !(cyc >= 4 && cyc <= 7);
         in_valid  = (n_sent < 6);
         if (in_valid && need_new) begin
            rand_data();
            need_new = 0;
         end
         #1; account();
         if (cyc == 4) begin
            checks++;
            if (in_ready_p !== 1'b0 || in_ready_o !== 1'b0) begin
               errors++;
               $display("FAIL b2b_full_ready: got p=%b o=%b, expected 0", in_ready_p, in_ready_o);
            end
         end
         if (cyc == 8) begin
            checks++;
            if (in_ready_p !== 1'b1 || in_ready_o !== 1'b1) begin
               errors++;
               $display("FAIL b2b_release_ready: got p=%b o=%b, expected 1", in_ready_p, in_ready_o);
            end
         end
         if (prev_stall) begin
            checks++;
            if (out_valid_p !== 1'b1 || y_p !== prev_yp || multi_p !== prev_mp ||
                out_valid_o !== 1'b1 || y_o !== prev_yo || multi_o !== prev_mo) begin
               errors++;
               $display("FAIL b2b_hold: got p v=%b y=%h o v=%b y=%h, expected v=1 y=%h/%h",
                        out_valid_p, y_p, out_valid_o, y_o, prev_yp, prev_yo);
            end
         end
         prev_stall = out_valid_p && !out_ready;
         prev_yp = y_p; prev_yo = y_o; prev_mp = multi_p; prev_mo = multi_o;
         if (acc_now) begin
            n_sent++;
            need_new = 1;
         end
         if (ret_now) begin
            n_got++;
            checks++;
            if (!have_exp || {multi_p, y_p} !== exp_p || {multi_o, y_o} !== exp_o) begin
               errors++;
               $display("FAIL b2b_result: got p=%h/%b o=%h/%b, expected p=%h o=%h",
                        y_p, multi_p, y_o, multi_o, exp_p, exp_o);
            end
         end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1; extra = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (out_valid_p !== 1'b0 || out_valid_o !== 1'b0) extra++;
         step();
      end
      checks++;
      if (n_sent != 6 || n_got != 6 || extra != 0) begin
         errors++;
         $display("FAIL b2b_count: got sent=%0d got=%0d extra=%0d, expected 6/6/0", n_sent, n_got, extra);
      end
   endtask

   task automatic test_reset_flush();
      int sent, spurious;
      sent = 0; spurious = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 10 && sent < 3; cyc++) begin
         in_valid = 1'b1;
         rand_data();
         #1; account();
         if (acc_now) sent++;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (sent != 3) begin
         errors++;
         $display("FAIL flush_fill: got %0d beats accepted, expected 3", sent);
      end
      srst = 1'b1;
      #1;
      checks++;
      if (in_ready_p !== 1'b0 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_in_ready: got p=%b o=%b, expected 0", in_ready_p, in_ready_o);
      end
      step();
      srst = 1'b0;
      q_p.delete(); q_o.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (i == 0) begin
            checks++;
            if (out_valid_p !== 1'b0 || out_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL flush_out_valid: got p=%b o=%b, expected 0", out_valid_p, out_valid_o);
            end
         end
         if (out_valid_p !== 1'b0 || out_valid_o !== 1'b0) spurious++;
         step();
      end
      checks++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL flush_stale: got %0d stale output cycles, expected 0", spurious);
      end
      test_single(5'b00010, 4'h2, 4'h2, 1'b0, "post_flush");
   endtask

   initial begin
      srst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; s = '0;
      test_reset();
      test_single(5'b00000, 4'hA, 4'hA, 1'b0, "s_zero");
      test_single(5'b01001, 4'h8, 4'h9, 1'b1, "s_multi");
      test_single(5'b10000, 4'h6, 4'h6, 1'b0, "s_last");
      test_random(60);
      test_back_to_back();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pmux_pipe.md
# pmux_pipe

Pipelined, flow-controlled successor to the combinational `$pmux` mapping. It resolves a WIDTH-bit parallel mux over S_WIDTH cases in NSTAGES = ceil(S_WIDTH/CHUNK) registered stages, with CHUNK select bits consumed per stage. It adds valid/ready handshaking, a selectable resolution mode, and a multi-select flag. It serves as the sequential mapping target wherever a wide `$pmux` must be retimed behind a handshake interface.

## Interface
- WIDTH, 1, data width of A, Y and each B slice
- S_WIDTH, 1, number of cases (select bits)
- CHUNK, 1, select bits resolved per stage (1..S_WIDTH)
- PRIORITY, 1, 1 = highest-index set select wins; 0 = OR of all selected B slices (one-hot semantics)
- CLK  in  1  clock. All state updates on the rising edge.
- SRST  in  1  reset. Synchronous and active-high.
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  stage 0 can accept a beat
- A  in  WIDTH  default value, used when no select bit is set
- B  in  WIDTH*S_WIDTH  case values. Slice i is B[WIDTH*(i+1)-1:WIDTH*i].
- S  in  S_WIDTH  select bits. Bit i selects slice i.
- OUT_VALID  out  1  result beat valid
- OUT_READY  in  1  downstream accepts the result
- Y  out  WIDTH  resolved value
- MULTI  out  1  more than one S bit was set in this beat

## Operation
- Stage k (k = 0..NSTAGES-1) handles select bits [k*CHUNK, min((k+1)*CHUNK, S_WIDTH)-1]. The last stage may be narrower.
- Each stage holds the following registers:
  - `acc`: WIDTH bits, the running result.
  - `hit`: any select bit seen so far.
  - `multi`: sticky flag.
  - The unconsumed B and S bits. Registers shrink stage by stage, and consumed bits are not carried forward.
- Stage input: `acc_in` = A at stage 0, otherwise the previous stage's `acc`. Let `n` = the number of set bits in this stage's chunk.
- PRIORITY=1:
  - If n > 0, `acc` ← the B slice of the highest set index in the chunk. Otherwise `acc` ← `acc_in`.
  - Result equals the combinational chain where later cases override earlier ones.
- PRIORITY=0:
  - If n > 0, `acc` ← OR of the selected slices, ORed with `acc_in` when `hit_in` is set. If n = 0 and `hit_in` is set, `acc` ← `acc_in`. If n = 0 and `hit_in` is clear, `acc` ← A.
  - Net result: Y = A when S = 0, otherwise Y = OR of all selected slices (A excluded).
- `multi` ← `multi_in` | (n > 1) | (`hit_in` & n > 0). `hit` ← `hit_in` | (n > 0).
- Y = last-stage `acc` and MULTI = last-stage `multi`, both registered outputs.
- S = 0 gives Y = A and MULTI = 0 in both modes.

## Timing
- Reset: every stage valid = 0, all data registers = 0. Therefore OUT_VALID = 0, Y = 0, MULTI = 0 on the cycle after SRST is sampled high.
- IN_READY = 0 while SRST = 1.
- Per-stage flow control:
  - stage_ready[k] = !valid[k] | stage_ready[k+1].
  - stage_ready[NSTAGES] = OUT_READY.
  - IN_READY = stage_ready[0] & !SRST. This is a combinational path from OUT_READY; no skid buffer.
- A stage loads when the previous stage is valid and the stage is ready. Otherwise it holds its data. Bubbles collapse.
- Latency is NSTAGES cycles from the accept edge (IN_VALID & IN_READY) to OUT_VALID, with no stalls. Throughput is 1 beat per cycle.
- Full pipeline with OUT_READY = 1: the output retires and a new input is accepted in the same cycle.
- OUT_READY = 0 while OUT_VALID = 1: Y, MULTI and OUT_VALID hold stable until accepted.
- SRST mid-operation: all in-flight beats are discarded at that edge, and no partial output appears.
- CHUNK ≥ S_WIDTH: single stage, latency 1.

## Structure
- Shared package (Verilog include):
  - the `ceil_div` function used for NSTAGES
  - the PRIORITY mode constants
- Sub-module `pmux_pipe_stage`:
  - one chunk resolver plus its register slice
  - parameters: WIDTH, NSEL (bits consumed), REM (bits carried forward), PRIORITY
- The top level instantiates NSTAGES stages in a generate loop and wires the ready chain.

## Test plan
All scenarios use WIDTH=4, S_WIDTH=5, CHUNK=2 (NSTAGES=3), A=4'hA, B4..B0 = 6, 8, 4, 2, 1.
- SRST held 2 cycles with IN_VALID=1 → IN_READY=0, no beat accepted. Then OUT_VALID=0, Y=0, MULTI=0.
- S=5'b00000 → Y=4'hA, MULTI=0, OUT_VALID exactly 3 cycles after accept.
- S=5'b01001, PRIORITY=1 → Y=8, MULTI=1. Same stimulus with PRIORITY=0 → Y=9, MULTI=1.
- S=5'b10000 → Y=6, MULTI=0 (exercises the narrow last stage).
- 6 back-to-back beats with OUT_READY low for cycles 4–7:
  - IN_READY drops once all 3 stages are full.
  - Y is held stable throughout the stall.
  - All 6 results arrive in order, with none dropped or duplicated.
- SRST pulsed with 3 beats in flight → OUT_VALID=0 next cycle. No stale result ever emerges, and the next beat has latency 3.
